// File: rtl/pll_cfg_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// counter word packing and the sequencer state type.
package pll_cfg_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C     = 6'd5;
    localparam logic [5:0] ADDR_K     = 6'd7;

    // Counter word is {odd[17], bypass[16], hi[15:8], lo[7:0]}
    localparam int CNT_W    = 18;
    localparam int CSEL_W   = 5;
    localparam int CSEL_LSB = CNT_W;
    localparam logic [CSEL_W-1:0] CSEL_C0 = '0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_MODE,
        ST_WR_N,
        ST_WR_M,
        ST_WR_C0,
        ST_WR_K,
        ST_START,
        ST_SETTLE,
        ST_WAIT_LOCK,
        ST_DONE
    } state_e;

    function automatic logic [31:0] pack_cnt(input logic [CNT_W-1:0] cnt,
                                             input logic [CSEL_W-1:0] sel);
        logic [31:0] w;
        w = '0;
        w[CNT_W-1:0] = cnt;
        w[CSEL_LSB +: CSEL_W] = sel;
        return w;
    endfunction

endpackage

// File: rtl/pll_cfg_sync2.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the
// management clock domain; clears to 0 on reset.
module pll_cfg_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_cfg_seq.sv
// Writes one PLL counter set to the reconfig management port, starts the
// reconfiguration and waits for re-lock. Lock timeout: PLL_CFG_LOCK_TIMEOUT_EN.
//   state      | meaning
//   IDLE       | waiting for cfg_start
//   MODE..START| one management write each, held while waitrequest
//   SETTLE     | LOCK_DELAY cycles before lock is trusted
//   WAIT_LOCK  | waiting for synchronised lock (or timeout)
//   DONE       | one-cycle completion pulse
module pll_cfg_seq
    import pll_cfg_pkg::*;
#(
    parameter int LOCK_DELAY   = 16,
    parameter int LOCK_TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic [CNT_W-1:0] cfg_m,
    input  logic [CNT_W-1:0] cfg_n,
    input  logic [CNT_W-1:0] cfg_c0,
    input  logic [31:0]      cfg_k,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [5:0]       mgmt_address,
    output logic             mgmt_write,
    output logic [31:0]      mgmt_writedata,
    input  logic             mgmt_waitrequest,
    input  logic             pll_locked
);

    localparam int DLY_W = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(LOCK_DELAY - 1);

    state_e           state_q, state_d, wr_next;
    logic [CNT_W-1:0] m_q, m_d, n_q, n_d, c0_q, c0_d;
    logic [31:0]      k_q, k_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             err_q, err_d;
    logic             locked_s;
    logic             tmo_hit;
    logic             wr;
    logic [5:0]       addr;
    logic [31:0]      wdata;
    logic             done;

    pll_cfg_sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

`ifdef PLL_CFG_LOCK_TIMEOUT_EN
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(LOCK_TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_hit = (tmo_q == '0);

    // Reloaded throughout SETTLE so it always starts full on WAIT_LOCK entry
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_SETTLE) begin
            tmo_d = TMO_LOAD;
        end else if (state_q == ST_WAIT_LOCK && !tmo_hit) begin
            tmo_d = tmo_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^LOCK_TIMEOUT;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wr_next = ST_IDLE;
        m_d     = m_q;
        n_d     = n_q;
        c0_d    = c0_q;
        k_d     = k_q;
        dly_d   = dly_q;
        err_d   = err_q;
        wr      = 1'b0;
        addr    = '0;
        wdata   = '0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    m_d     = cfg_m;
                    n_d     = cfg_n;
                    c0_d    = cfg_c0;
                    k_d     = cfg_k;
                    err_d   = 1'b0;
                    state_d = ST_MODE;
                end
            end
            ST_MODE: begin
                wr      = 1'b1;
                addr    = ADDR_MODE;
                wr_next = ST_WR_N;
            end
            ST_WR_N: begin
                wr      = 1'b1;
                addr    = ADDR_N;
                wdata   = pack_cnt(n_q, '0);
                wr_next = ST_WR_M;
            end
            ST_WR_M: begin
                wr      = 1'b1;
                addr    = ADDR_M;
                wdata   = pack_cnt(m_q, '0);
                wr_next = ST_WR_C0;
            end
            ST_WR_C0: begin
                wr      = 1'b1;
                addr    = ADDR_C;
                wdata   = pack_cnt(c0_q, CSEL_C0);
                wr_next = ST_WR_K;
            end
            ST_WR_K: begin
                wr      = 1'b1;
                addr    = ADDR_K;
                wdata   = k_q;
                wr_next = ST_START;
            end
            ST_START: begin
                wr      = 1'b1;
                addr    = ADDR_START;
                wdata   = 32'd1;
                wr_next = ST_SETTLE;
                dly_d   = DLY_LOAD;
            end
            ST_SETTLE: begin
                if (dly_q == '0) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = ST_DONE;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr && !mgmt_waitrequest) begin
            state_d = wr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            n_q     <= '0;
            c0_q    <= '0;
            k_q     <= '0;
            dly_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            n_q     <= n_d;
            c0_q    <= c0_d;
            k_q     <= k_d;
            dly_q   <= dly_d;
            err_q   <= err_d;
        end
    end

    assign cfg_busy       = (state_q != ST_IDLE);
    assign cfg_done       = done;
    assign cfg_err        = err_q;
    assign mgmt_write     = wr;
    assign mgmt_address   = addr;
    assign mgmt_writedata = wdata;

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Bench for pll_cfg_seq: each request is expanded into a per-cycle expected
// trace from the sequencing rules, then replayed against the design.
module tb_pll_cfg_seq;

    localparam int LD   = 16;
    localparam int TMO  = 100;
    localparam int NMAX = 512;
    localparam int ACC  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [17:0] cfg_m, cfg_n, cfg_c0;
    logic [31:0] cfg_k;
    logic        cfg_busy, cfg_done, cfg_err;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;
    logic        pll_locked;

    always #5 clk = ~clk;

    pll_cfg_seq #(.LOCK_DELAY(LD), .LOCK_TIMEOUT(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_start        (cfg_start),
        .cfg_m            (cfg_m),
        .cfg_n            (cfg_n),
        .cfg_c0           (cfg_c0),
        .cfg_k            (cfg_k),
        .cfg_busy         (cfg_busy),
        .cfg_done         (cfg_done),
        .cfg_err          (cfg_err),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic prev_err = 1'b0;

    logic        e_wr[NMAX];
    logic [5:0]  e_addr[NMAX];
    logic [31:0] e_data[NMAX];
    logic        e_busy[NMAX], e_done[NMAX], e_err[NMAX];
    logic        d_start[NMAX], d_wreq[NMAX];
    int          n_tr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic put(input int j, input logic wr, input logic [5:0] a, input logic [31:0] d,
                       input logic busy, input logic done, input logic err,
                       input logic st, input logic wq);
        e_wr[j] = wr;   e_addr[j] = a;    e_data[j] = d;
        e_busy[j] = busy; e_done[j] = done; e_err[j] = err;
        d_start[j] = st;  d_wreq[j] = wq;
    endtask

    function automatic int wait_entry(input int st[6]);
        int s;
        s = ACC + 1 + LD;
        for (int i = 0; i < 6; i++) s += st[i] + 1;
        return s;
    endfunction

    // Expected trace: 3 idle cycles, accept, six writes (each stretched by
    // its stall count), LD settle cycles, lock wait, DONE, 2 idle cycles.
    task automatic build(input logic [17:0] m, input logic [17:0] n, input logic [17:0] c0,
                         input logic [31:0] k, input int st[6], input int lock_at);
        logic [5:0]  a[6];
        logic [31:0] d[6];
        int j, t;
        logic tmo;
        a = '{6'd0, 6'd3, 6'd4, 6'd5, 6'd7, 6'd2};
        d = '{32'd0, {14'b0, n}, {14'b0, m}, {14'b0, c0}, k, 32'd1};
        for (j = 0; j < ACC; j++) put(j, 0, 0, 0, 0, 0, prev_err, 0, 1'($urandom));
        put(ACC, 0, 0, 0, 0, 0, prev_err, 1, 1'($urandom));
        j = ACC + 1;
        for (int i = 0; i < 6; i++)
            for (int s = 0; s <= st[i]; s++) begin
                put(j, 1, a[i], d[i], 1, 0, 0, ($urandom % 4) == 0, s < st[i]);
                j++;
            end
        for (int s = 0; s < LD; s++) begin
            put(j, 0, 0, 0, 1, 0, 0, ($urandom % 4) == 0, 1'($urandom));
            j++;
        end
        tmo = 1'b0;
        for (t = j; t < NMAX - 8; t++) begin
            put(t, 0, 0, 0, 1, 0, 0, ($urandom % 4) == 0, 1'($urandom));
            if (t - 2 >= lock_at) break;
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
            if (t - j == TMO - 1) begin
                tmo = 1'b1;
                break;
            end
`endif
        end
        j = t + 1;
        put(j, 0, 0, 0, 1, 1, tmo, ($urandom % 2) == 0, 1'($urandom));
        put(j + 1, 0, 0, 0, 0, 0, tmo, 0, 1'($urandom));
        put(j + 2, 0, 0, 0, 0, 0, tmo, 0, 1'($urandom));
        n_tr = j + 3;
    endtask

    task automatic run(input logic [17:0] m, input logic [17:0] n, input logic [17:0] c0,
                       input logic [31:0] k, input int lock_at, input int abort_j);
        for (int j = 0; j < n_tr; j++) begin
            cfg_start        = d_start[j];
            mgmt_waitrequest = d_wreq[j];
            pll_locked       = (j >= lock_at);
            rst              = (j == abort_j);
            if (j == ACC) begin
                cfg_m = m; cfg_n = n; cfg_c0 = c0; cfg_k = k;
            end else begin
                cfg_m = 18'($urandom); cfg_n = 18'($urandom);
                cfg_c0 = 18'($urandom); cfg_k = $urandom;
            end
            @(negedge clk);
            chk($sformatf("write@%0d", j), mgmt_write, e_wr[j]);
            chk($sformatf("busy@%0d", j), cfg_busy, e_busy[j]);
            chk($sformatf("done@%0d", j), cfg_done, e_done[j]);
            chk($sformatf("err@%0d", j), cfg_err, e_err[j]);
            if (e_wr[j]) begin
                chk($sformatf("addr@%0d", j), mgmt_address, e_addr[j]);
                chk($sformatf("data@%0d", j), mgmt_writedata, e_data[j]);
            end
            @(posedge clk); #1;
            if (j == abort_j) begin
                rst = 1'b0;
                cfg_start = 1'b0;
                @(negedge clk);
                chk("rst_write", mgmt_write, 0);
                chk("rst_busy", cfg_busy, 0);
                chk("rst_done", cfg_done, 0);
                chk("rst_err", cfg_err, 0);
                @(posedge clk); #1;
                prev_err = 1'b0;
                return;
            end
        end
        prev_err = e_err[n_tr - 1];
    endtask

    task automatic request(input logic [17:0] m, input logic [17:0] n, input logic [17:0] c0,
                           input logic [31:0] k, input int st[6], input int lock_at,
                           input int abort_j);
        build(m, n, c0, k, st, lock_at);
        run(m, n, c0, k, lock_at, abort_j);
    endtask

    initial begin
        int st[6];
        int w, lk;
        rst = 1'b1; cfg_start = 1'b0; cfg_m = '0; cfg_n = '0; cfg_c0 = '0; cfg_k = '0;
        mgmt_waitrequest = 1'b0; pll_locked = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_write", mgmt_write, 0);
        chk("reset_addr", mgmt_address, 0);
        chk("reset_data", mgmt_writedata, 0);
        chk("reset_busy", cfg_busy, 0);
        chk("reset_done", cfg_done, 0);
        chk("reset_err", cfg_err, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Nominal 82.75 MHz set, lock held high
        st = '{0, 0, 0, 0, 0, 0};
        request(18'h00404, 18'h10000, 18'h20302, 32'h467E4E65, st, -100, -1);

        // Three-cycle stall during the M write
        st = '{0, 0, 3, 0, 0, 0};
        request(18'h00404, 18'h10000, 18'h20302, 32'h467E4E65, st, -100, -1);

        // Second start while busy must be ignored
        st = '{0, 0, 0, 0, 0, 0};
        build(18'h00505, 18'h00101, 18'h00303, 32'h12345678, st, -100);
        d_start[ACC + 3] = 1'b1;
        run(18'h00505, 18'h00101, 18'h00303, 32'h12345678, -100, -1);

        // Reset during the C0 write, then a full fresh sequence
        build(18'h00606, 18'h00202, 18'h00404, 32'hCAFEF00D, st, -100);
        run(18'h00606, 18'h00202, 18'h00404, 32'hCAFEF00D, -100, ACC + 4);
        request(18'h00707, 18'h00303, 18'h00505, 32'h0BADBEEF, st, -100, -1);

        // Lock low through SETTLE, rises 5 cycles into WAIT_LOCK
        w = wait_entry(st);
        request(18'h00808, 18'h00101, 18'h00202, 32'h55AA55AA, st, w + 5, -1);

`ifdef PLL_CFG_LOCK_TIMEOUT_EN
        // No lock at all: timeout, then the next accept clears cfg_err
        request(18'h00909, 18'h00101, 18'h00202, 32'h11111111, st, 100000, -1);
        request(18'h00A0A, 18'h00101, 18'h00202, 32'h22222222, st, -100, -1);
`endif

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 6; i++)
                st[i] = (($urandom % 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            w = wait_entry(st);
            case ($urandom % 4)
                0:       lk = -100;
                1:       lk = w - 6 + int'($urandom_range(0, 8));
                default: lk = w + int'($urandom_range(0, 20));
            endcase
`ifdef PLL_CFG_LOCK_TIMEOUT_EN
            if (($urandom % 6) == 0) lk = 100000;
`endif
            request(18'($urandom), 18'($urandom), 18'($urandom), $urandom, st, lk, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
